multicycle_control: RTL

Main control state machine for the multicycle MIPS datapath. It decodes the 6-bit opcode latched in the instruction register and steps each instruction through fetch, decode, execute, memory and writeback cycles. It drives every datapath enable and mux select, including `Branch`. Downstream logic ANDs `Branch` with the ALU `Zero` flag and ORs the result with `PCWrite` to form the PC enable.

---
 rtl/mc_ctrl_pkg.sv | 56 +++++
 rtl/mc_ctrl_outdec.sv | 65 ++++++
 rtl/multicycle_control.sv | 81 ++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller:
// state codes, opcode constants, ALUOp/PCSrc encodings and the
// packed control word handed from the output decoder to the top.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control word decoder (Moore outputs).
// Ports:
//   i_state : current FSM state code (4 bits, codes 12-15 unused)
//   o_ctrl  : packed datapath control word; all zero for unused codes
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.irwrite = 1'b1;
        o_ctrl.alusrcb = SRCB_FOUR;
        o_ctrl.aluop   = ALUOP_ADD;
        o_ctrl.pcsrc   = PCSRC_ALURES;
        o_ctrl.pcwrite = 1'b1;
      end
      S_DECODE: begin
        o_ctrl.alusrcb = SRCB_IMMSH2;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: o_ctrl.iord = 1'b1;
      S_MEMWB: begin
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.iord     = 1'b1;
        o_ctrl.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_B;
        o_ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.regdst   = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_B;
        o_ctrl.aluop   = ALUOP_SUB;
        o_ctrl.pcsrc   = PCSRC_ALUOUT;
        o_ctrl.branch  = 1'b1;
      end
      S_ADDIWB: o_ctrl.regwrite = 1'b1;
      S_JUMP: begin
        o_ctrl.pcsrc   = PCSRC_JUMP;
        o_ctrl.pcwrite = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset (-> FETCH)
//   Op              : opcode from the instruction register
//   IorD..Branch    : datapath enables / mux selects (Moore outputs)
//   State           : current state code for debug
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] Op,
  output logic           IorD,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           RegDst,
  output logic           MemtoReg,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSrc,
  output logic           PCWrite,
  output logic           Branch,
  output logic [3:0]     State
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  ctrl_t      w_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Unrecognised opcodes and unused state codes both fall back to FETCH.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_next = S_MEMWB;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  assign IorD     = w_ctrl.iord;
  assign MemWrite = w_ctrl.memwrite;
  assign IRWrite  = w_ctrl.irwrite;
  assign RegDst   = w_ctrl.regdst;
  assign MemtoReg = w_ctrl.memtoreg;
  assign RegWrite = w_ctrl.regwrite;
  assign ALUSrcA  = w_ctrl.alusrca;
  assign ALUSrcB  = w_ctrl.alusrcb;
  assign ALUOp    = w_ctrl.aluop;
  assign PCSrc    = w_ctrl.pcsrc;
  assign PCWrite  = w_ctrl.pcwrite;
  assign Branch   = w_ctrl.branch;
  assign State    = r_state;

endmodule
